// File: rtl/glitch_scheduler_if.sv
// rtl/glitch_scheduler_if.sv - slot configuration write bus for the glitch scheduler
interface glitch_scheduler_if #(
    parameter int NUM_SLOTS = 4,
    parameter int CNT_W     = 16,
    parameter int WID_W     = 4
);
    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    logic              cfg_we;
    logic [SLOT_W-1:0] cfg_slot;
    logic [CNT_W-1:0]  cfg_offset;
    logic [WID_W-1:0]  cfg_width;
    logic              cfg_en;

    modport master (output cfg_we, cfg_slot, cfg_offset, cfg_width, cfg_en);
    modport slave  (input  cfg_we, cfg_slot, cfg_offset, cfg_width, cfg_en);
endinterface

// File: rtl/glitch_scheduler.sv
// rtl/glitch_scheduler.sv - trigger-relative multi-window clock-glitch sequencer
module glitch_scheduler #(
    parameter int NUM_SLOTS = 4,
    parameter int CNT_W     = 16,
    parameter int WID_W     = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    glitch_scheduler_if.slave    cfg,
    input  logic                 arm,
    input  logic                 abort,
    input  logic                 trigger,
    output logic                 glitch_en,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     cycle_cnt,
    output logic [NUM_SLOTS-1:0] fired_mask
);
    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN, S_DONE} state_t;

    state_t                             state_q, state_d;
    logic                               trig_s1_q, trig_s2_q, trig_d_q;
    logic [NUM_SLOTS-1:0][CNT_W-1:0]    offset_q, offset_d;
    logic [NUM_SLOTS-1:0][WID_W-1:0]    width_q, width_d;
    logic [NUM_SLOTS-1:0]               en_q, en_d;
    logic [CNT_W-1:0]                   cnt_q, cnt_d, cnt_inc, eval_cnt;
    logic                               glitch_q, glitch_d, busy_q, busy_d, done_q, done_d;
    logic [NUM_SLOTS-1:0]               fired_q, fired_d, hit, start, past;
    logic [NUM_SLOTS-1:0][CNT_W:0]      win_end;
    logic                               trig_rise, trig_fall, cfg_open, all_done;

    assign trig_rise = trig_s2_q & ~trig_d_q;
    assign trig_fall = ~trig_s2_q & trig_d_q;
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign cfg_open  = (state_q == S_IDLE) || (state_q == S_DONE);
    assign all_done  = (|en_q) && (&past);

    always_comb begin
        offset_d = offset_q;
        width_d  = width_q;
        en_d     = en_q;
        if (cfg.cfg_we && cfg_open) begin
            offset_d[cfg.cfg_slot] = cfg.cfg_offset;
            width_d[cfg.cfg_slot]  = (cfg.cfg_width == '0) ? WID_W'(1) : cfg.cfg_width;
            en_d[cfg.cfg_slot]     = cfg.cfg_en;
        end
    end

    // Windows are evaluated against the count the next edge will hold, so
    // glitch_en and cycle_cnt update together. One extra bit keeps end clipping implicit.
    always_comb begin
        eval_cnt = (state_q == S_RUN) ? cnt_inc : '0;
        hit      = '0;
        start    = '0;
        past     = '0;
        win_end  = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            win_end[i] = {1'b0, offset_q[i]} + (CNT_W+1)'(width_q[i]) - (CNT_W+1)'(1);
            hit[i]     = en_q[i] && (eval_cnt >= offset_q[i]) && ({1'b0, eval_cnt} <= win_end[i]);
            start[i]   = en_q[i] && (eval_cnt == offset_q[i]);
            past[i]    = !en_q[i] || ({1'b0, eval_cnt} > win_end[i]);
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        glitch_d = 1'b0;
        fired_d  = fired_q;
        unique case (state_q)
            S_IDLE:  if (arm) state_d = S_ARMED;
            S_ARMED: if (trig_rise) begin
                state_d  = S_RUN;
                cnt_d    = '0;
                glitch_d = |hit;
                fired_d  = start;
            end
            S_RUN: begin
                if (trig_fall || (cnt_q == '1)) begin
                    state_d = S_DONE;
                end else if (all_done) begin
                    state_d = S_DONE;
                    cnt_d   = cnt_inc;
                end else begin
                    cnt_d    = cnt_inc;
                    glitch_d = |hit;
                    fired_d  = fired_q | start;
                end
            end
            S_DONE:  if (arm) state_d = S_ARMED;
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            glitch_d = 1'b0;
            fired_d  = fired_q;
        end
        busy_d = (state_d == S_ARMED) || (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            trig_s1_q <= 1'b0;
            trig_s2_q <= 1'b0;
            trig_d_q  <= 1'b0;
            offset_q  <= '0;
            width_q   <= '0;
            en_q      <= '0;
            cnt_q     <= '0;
            glitch_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            fired_q   <= '0;
        end else begin
            state_q   <= state_d;
            trig_s1_q <= trigger;
            trig_s2_q <= trig_s1_q;
            trig_d_q  <= trig_s2_q;
            offset_q  <= offset_d;
            width_q   <= width_d;
            en_q      <= en_d;
            cnt_q     <= cnt_d;
            glitch_q  <= glitch_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            fired_q   <= fired_d;
        end
    end

    assign glitch_en  = glitch_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign cycle_cnt  = cnt_q;
    assign fired_mask = fired_q;
endmodule

// File: doc/glitch_scheduler.md
Name: glitch_scheduler

Overview:
- Hardware fault-injection sequencer for the picochip clock-glitch bench and FPGA rig.
- Synchronises the gpio trigger bit, counts core clock cycles from its rising edge, and drives glitch_en during up to NUM_SLOTS programmed cycle windows.
- glitch_en is XORed externally into the core clock, or gates the D-flip mask.
- Replaces the hard-coded per-cycle injection with a configurable, repeatable schedule.

Parameters:
- NUM_SLOTS, 4, number of independent glitch windows.
- CNT_W, 16, width of the cycle counter and of slot offsets.
- WID_W, 4, width of the per-slot pulse-width field.

Ports:
- clk  in  1  system clock, un-glitched.
- resetn  in  1  asynchronous active-low reset; this is the codebase's clock/reset naming, and the polarity and synchronicity are fixed.
- cfg_we  in  1  configuration write strobe.
- cfg_slot  in  $clog2(NUM_SLOTS)  slot index being written.
- cfg_offset  in  CNT_W  cycle offset after the trigger rising edge.
- cfg_width  in  WID_W  pulse width in cycles; 0 is treated as 1.
- cfg_en  in  1  slot enable.
- arm  in  1  single-cycle pulse; arms the scheduler.
- abort  in  1  single-cycle pulse; returns to IDLE.
- trigger  in  1  asynchronous trigger (gpio[TRIGGERBIT]).
- glitch_en  out  1  registered glitch request.
- busy  out  1  high in ARMED or RUN.
- done  out  1  high in DONE.
- cycle_cnt  out  CNT_W  cycles elapsed since entering RUN.
- fired_mask  out  NUM_SLOTS  sticky; bit i set once slot i has started its pulse.

Behaviour:
- Reset values (asynchronous):
  - Outputs: glitch_en=0, busy=0, done=0, cycle_cnt=0, fired_mask=0.
  - State: state=IDLE, all slot registers cleared (disabled).
- Trigger path:
  - trigger passes through a 2-flop synchroniser, then a 1-flop edge detector.
  - trig_rise/trig_fall are therefore seen 3 clk edges after the pin transitions.
- Configuration:
  - A cfg_we write takes effect only in IDLE or DONE; it is ignored in ARMED and RUN.
  - A write updates offset, width and en of slot cfg_slot at the next edge.
- IDLE:
  - arm -> ARMED.
  - trigger activity is ignored.
- ARMED:
  - On trig_rise -> RUN, with cycle_cnt=0 and fired_mask=0 at that edge.
  - If the trigger is already high when armed, no rise is detected; the scheduler waits for a genuine low-to-high edge.
- RUN:
  - cycle_cnt increments by 1 each edge.
  - glitch_en is high in exactly those cycles where, for some enabled slot i, cycle_cnt is in [offset_i, offset_i + max(width_i,1) - 1].
  - glitch_en is therefore computed from the next-state count and registered, so it changes on the same edge as cycle_cnt.
  - Windows of different slots may overlap; glitch_en is their OR, with no gap and no extension beyond the union.
  - A window end beyond 2^CNT_W-1 is clipped at the saturation point.
  - fired_mask[i] is set on the edge that starts slot i's window.
- RUN exits to DONE when any of these occurs:
  - trig_fall; remaining windows are cancelled.
  - cycle_cnt saturates at all-ones.
  - Every enabled slot's window has completed.
  - If no slot is enabled, RUN exits on trig_fall or saturation only.
- DONE:
  - glitch_en=0, done=1.
  - cycle_cnt holds its final value.
  - arm -> ARMED (new run; fired_mask cleared at the next trig_rise).
- abort (any state): next edge -> IDLE, glitch_en=0, cycle_cnt=0. Slot configuration is retained.
- Precedence on the same edge: abort > arm > trig_fall > window logic.
  - In RUN, arm is ignored.
  - A trig_fall and a window start in the same edge: the window does not start.
- resetn asserted mid-RUN: glitch_en drops asynchronously, with no partial pulse after release. Slot configuration is lost.

Test Plan:
- Single window:
  - Stimulus: slot0 offset=613 width=1, arm, raise trigger at t0.
  - Response: glitch_en high for exactly one cycle with cycle_cnt=613; fired_mask=0001; done after trigger falls or after cycle 613.
- Two slots:
  - Stimulus: slot0 613/1, slot1 1256/1.
  - Response: exactly two 1-cycle pulses at cycle_cnt 613 and 1256; fired_mask=0011; DONE at cycle 1257.
- Overlap and width:
  - Stimulus: slot0 100/4, slot1 102/5, slot2 50/0.
  - Response: pulse at 50 for 1 cycle; glitch_en continuously high over cycles 100..106 (7 cycles).
- Trigger fall:
  - Stimulus: slot0 500/1, trigger low at cycle 200.
  - Response: DONE with no pulse; fired_mask=0; cycle_cnt frozen near 203.
- Abort and config lock:
  - Stimulus: abort at cycle 50 of RUN; then a cfg_we in ARMED changing slot0 offset.
  - Response: IDLE, glitch_en=0, cycle_cnt=0; the ARMED write is ignored and the original offset is used on the next run.
- Reset mid-pulse:
  - Stimulus: slot0 10/8, resetn low at cycle 12.
  - Response: glitch_en=0 immediately; all outputs at reset values; after release, trigger edges are ignored until arm.
